// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: controller states, default field polynomial and
// elaboration-time helpers used by the Itoh-Tsujii divider.
package gf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    FINSQR,
    FINMUL,
    DONE
  } gf_state_t;

  // Widest field gf_sqr can handle; callers zero-extend and truncate around it.
  localparam int unsigned GF_MAXW = 571;

  localparam logic [163:0] GF_POLY163 = (164'd1 << 163) | 164'hC9;

  function automatic int unsigned bitlen(input int unsigned v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  function automatic int unsigned popcount(input int unsigned v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [GF_MAXW-1:0] gf_sqr(input logic [GF_MAXW-1:0] x,
                                                input logic [GF_MAXW:0]   poly,
                                                input int unsigned        m);
    logic [2*GF_MAXW-1:0] t;
    logic [2*GF_MAXW-1:0] pe;
    int unsigned          i;
    t = '0;
    for (int unsigned j = 0; j < GF_MAXW; j++) t[2*j] = x[j];
    pe = (2*GF_MAXW)'(poly);
    // Fold high-order terms back from the top so each xor only disturbs lower bits.
    for (int unsigned j = 0; j < 2*GF_MAXW-1; j++) begin
      i = 2*GF_MAXW - 2 - j;
      if (i >= m && t[i]) t = t ^ (pe << (i - m));
    end
    return t[GF_MAXW-1:0];
  endfunction

endpackage

// File: rtl/gf_mult_serial.sv
// Bit-serial MSB-first GF(2^M) multiplier: the first partial product is formed
// on the start cycle, then M-1 more cycles; done pulses while p holds a*b.
module gf_mult_serial
  import gf_pkg::*;
#(
  parameter int unsigned M    = 163,
  parameter logic [M:0]  POLY = (M+1)'(GF_POLY163)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p,
  output logic         done
);

  localparam int unsigned CW = $clog2(M);

  logic [M-1:0]  a_q, a_d, b_q, b_d, p_q, p_d, p_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    p_sh   = {p_q[M-2:0], 1'b0} ^ (p_q[M-1] ? POLY[M-1:0] : '0);
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      a_d   = a;
      b_d   = {b[M-2:0], 1'b0};
      p_d   = b[M-1] ? a : '0;
      cnt_d = CW'(M - 1);
    end else if (cnt_q != '0) begin
      p_d    = p_sh ^ (b_q[M-1] ? a_q : '0);
      b_d    = {b_q[M-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: rtl/gf_div_it.sv
// GF(2^M) divider/inverter: B^-1 = (B^(2^(M-1)-1))^2 via an Itoh-Tsujii chain
// walked over the bits of M-1, then an optional multiply by A.
module gf_div_it
  import gf_pkg::*;
#(
  parameter int unsigned M    = 163,
  parameter logic [M:0]  POLY = (M+1)'(GF_POLY163)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] Q
);

  localparam int unsigned CW   = $clog2(M);
  localparam int unsigned IW   = $clog2(bitlen(M));
  localparam int unsigned IDXN = 1 << IW;
  localparam int unsigned IDX0 = bitlen(M - 1) - 2;
  localparam logic [IDXN-1:0] M1_BITS = IDXN'(M - 1);

  gf_state_t     state_q, state_d;
  logic [M-1:0]  a_q, a_d, b_q, b_d, beta_q, beta_d, saved_q, saved_d, q_q, q_d;
  logic [CW-1:0] k_q, k_d, sqr_cnt_q, sqr_cnt_d, k_next;
  logic [IW-1:0] idx_q, idx_d;
  logic          op_q, op_d, add_q, add_d, issued_q, issued_d, err_q, err_d;
  logic          mul_start, mul_done;
  logic [M-1:0]  mul_b, mul_p, sqr_w;

  assign sqr_w = M'(gf_sqr(GF_MAXW'(beta_q), (GF_MAXW+1)'(POLY), M));

  gf_mult_serial #(.M(M), .POLY(POLY)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (beta_q),
    .b     (mul_b),
    .p     (mul_p),
    .done  (mul_done)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    beta_d    = beta_q;
    saved_d   = saved_q;
    k_d       = k_q;
    sqr_cnt_d = sqr_cnt_q;
    idx_d     = idx_q;
    add_d     = add_q;
    issued_d  = issued_q;
    q_d       = q_q;
    err_d     = err_q;
    mul_start = 1'b0;
    mul_b     = add_q ? b_q : saved_q;
    k_next    = add_q ? k_q : (k_q << 1);
    case (state_q)
      IDLE: if (start) begin
        a_d     = A;
        b_d     = B;
        op_d    = op;
        err_d   = 1'b0;
        state_d = LOAD;
      end
      LOAD: if (b_q == '0) begin
        err_d   = 1'b1;
        q_d     = '0;
        state_d = DONE;
      end else begin
        beta_d    = b_q;
        saved_d   = b_q;
        k_d       = CW'(1);
        sqr_cnt_d = CW'(1);
        idx_d     = IW'(IDX0);
        add_d     = 1'b0;
        state_d   = SQR;
      end
      SQR: begin
        beta_d = sqr_w;
        if (sqr_cnt_q == CW'(1)) begin
          issued_d = 1'b0;
          state_d  = MUL;
        end else begin
          sqr_cnt_d = sqr_cnt_q - 1'b1;
        end
      end
      MUL: if (!issued_q) begin
        mul_start = 1'b1;
        issued_d  = 1'b1;
      end else if (mul_done) begin
        beta_d = mul_p;
        // A doubling step whose bit of M-1 is set is followed by an add step
        // before the index moves on; the index only advances after the add.
        if (!add_q && M1_BITS[idx_q]) begin
          add_d     = 1'b1;
          k_d       = (k_q << 1) | CW'(1);
          sqr_cnt_d = CW'(1);
          state_d   = SQR;
        end else begin
          add_d = 1'b0;
          k_d   = k_next;
          if (idx_q == '0) begin
            state_d = FINSQR;
          end else begin
            idx_d     = idx_q - 1'b1;
            saved_d   = mul_p;
            sqr_cnt_d = k_next;
            state_d   = SQR;
          end
        end
      end
      FINSQR: begin
        beta_d   = sqr_w;
        issued_d = 1'b0;
        if (op_q) begin
          q_d     = sqr_w;
          state_d = DONE;
        end else begin
          state_d = FINMUL;
        end
      end
      FINMUL: begin
        mul_b = a_q;
        if (!issued_q) begin
          mul_start = 1'b1;
          issued_d  = 1'b1;
        end else if (mul_done) begin
          q_d     = mul_p;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      beta_q    <= '0;
      saved_q   <= '0;
      k_q       <= '0;
      sqr_cnt_q <= '0;
      idx_q     <= '0;
      add_q     <= 1'b0;
      issued_q  <= 1'b0;
      q_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      beta_q    <= beta_d;
      saved_q   <= saved_d;
      k_q       <= k_d;
      sqr_cnt_q <= sqr_cnt_d;
      idx_q     <= idx_d;
      add_q     <= add_d;
      issued_q  <= issued_d;
      q_q       <= q_d;
      err_q     <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign Q    = q_q;

endmodule

// File: tb/tb_gf_div_it.sv
// Scoreboard bench for gf_div_it: an M=8 (AES field) instance with directed
// vectors and a default M=163 instance checked against a behavioural model.
module tb_gf_div_it;

  localparam logic [163:0] POLY163 = (164'd1 << 163) | 164'hC9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         s8 = 1'b0, op8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0, q8;
  logic         busy8, done8, err8;
  logic         s163 = 1'b0, op163 = 1'b0;
  logic [162:0] a163 = '0, b163 = '0, q163;
  logic         busy163, done163, err163;

  gf_div_it #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .err(err8), .Q(q8)
  );

  gf_div_it #(.M(163), .POLY(POLY163)) dut163 (
    .clk(clk), .rst(rst), .start(s163), .op(op163), .A(a163), .B(b163),
    .busy(busy163), .done(done163), .err(err163), .Q(q163)
  );

  typedef struct {
    logic [162:0] q;
    logic         err;
    int unsigned  exp_cyc;
    logic         chk_inv;
    logic [162:0] b;
    int unsigned  tag;
  } exp_t;

  exp_t sb8[$];
  exp_t sb163[$];
  exp_t e8, e163;
  int passed = 0;
  int total  = 0;

  function automatic logic [162:0] mul163(input logic [162:0] a, input logic [162:0] b);
    logic [162:0] r, aa;
    logic [163:0] t;
    r  = '0;
    aa = a;
    for (int i = 0; i < 163; i++) begin
      if (b[i]) r = r ^ aa;
      t = {aa, 1'b0};
      if (t[163]) t = t ^ POLY163;
      aa = t[162:0];
    end
    return r;
  endfunction

  // Fermat: B^(2^163-2) = product of B^(2^i) for i = 1..162.
  function automatic logic [162:0] inv163(input logic [162:0] b);
    logic [162:0] s, r;
    s = b;
    r = 163'd1;
    for (int i = 1; i < 163; i++) begin
      s = mul163(s, s);
      r = mul163(r, s);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (sb8.size() == 0) begin
        total++;
        $display("FAIL m8_spurious_done: got done=1 want 0 (cyc %0d)", cyc);
      end else begin
        e8 = sb8.pop_front();
        chk($sformatf("m8_q_t%0d", e8.tag), 163'(q8), e8.q);
        chk($sformatf("m8_err_t%0d", e8.tag), 163'(err8), 163'(e8.err));
        chk($sformatf("m8_lat_t%0d", e8.tag), 163'(cyc), 163'(e8.exp_cyc));
      end
    end
    if (done163) begin
      if (sb163.size() == 0) begin
        total++;
        $display("FAIL m163_spurious_done: got done=1 want 0 (cyc %0d)", cyc);
      end else begin
        e163 = sb163.pop_front();
        chk($sformatf("m163_q_t%0d", e163.tag), q163, e163.q);
        chk($sformatf("m163_err_t%0d", e163.tag), 163'(err163), 163'(e163.err));
        chk($sformatf("m163_lat_t%0d", e163.tag), 163'(cyc), 163'(e163.exp_cyc));
        if (e163.chk_inv) chk("m163_b_times_qinv", mul163(e163.b, q163), 163'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    int unsigned n = 0;
    while (busy8 && n < 3000) begin step(); n++; end
    if (busy8) begin total++; $display("FAIL m8_idle_timeout: got busy=1 want 0"); end
  endtask

  task automatic idle163();
    int unsigned n = 0;
    while (busy163 && n < 5000) begin step(); n++; end
    if (busy163) begin total++; $display("FAIL m163_idle_timeout: got busy=1 want 0"); end
  endtask

  task automatic drain8();
    int unsigned n = 0;
    while (sb8.size() != 0 && n < 3000) begin step(); n++; end
    if (sb8.size() != 0) begin total++; $display("FAIL m8_done_timeout: got %0d pending want 0", sb8.size()); end
  endtask

  task automatic drain163();
    int unsigned n = 0;
    while (sb163.size() != 0 && n < 5000) begin step(); n++; end
    if (sb163.size() != 0) begin total++; $display("FAIL m163_done_timeout: got %0d pending want 0", sb163.size()); end
  endtask

  task automatic req8(input logic o, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic ee, input int unsigned lat,
                      input bit push, input int unsigned hold, input int unsigned tag,
                      output int unsigned acc);
    exp_t e;
    idle8();
    s8 = 1'b1; op8 = o; a8 = a; b8 = b;
    step();
    acc = cyc;
    if (push) begin
      e.q = 163'(eq); e.err = ee; e.exp_cyc = acc + lat - 1;
      e.chk_inv = 1'b0; e.b = '0; e.tag = tag;
      sb8.push_back(e);
    end
    repeat (hold) step();
    s8 = 1'b0;
  endtask

  task automatic req163(input logic o, input logic [162:0] a, input logic [162:0] b,
                        input logic [162:0] eq, input logic ee, input int unsigned lat,
                        input logic ci, input int unsigned tag);
    exp_t e;
    idle163();
    s163 = 1'b1; op163 = o; a163 = a; b163 = b;
    step();
    e.q = eq; e.err = ee; e.exp_cyc = cyc + lat - 1;
    e.chk_inv = ci; e.b = b; e.tag = tag;
    sb163.push_back(e);
    s163 = 1'b0;
  endtask

  initial begin
    int unsigned acc, n;
    logic [162:0] bv, cv, iv;
    exp_t e;
    bv = 163'h2_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C;
    cv = 163'h5_A5A5_1234_DEAD_BEEF_0BAD_F00D_C0FF_EE11_2233_4455;

    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy8", 163'(busy8), 163'd0);
    chk("rst_done8", 163'(done8), 163'd0);
    chk("rst_err8", 163'(err8), 163'd0);
    chk("rst_q8", 163'(q8), 163'd0);
    chk("rst_busy163", 163'(busy163), 163'd0);
    chk("rst_q163", q163, 163'd0);

    // M=163: invert, then divide B*C by B, then divide-by-zero.
    iv = inv163(bv);
    req163(1'b1, '0, bv, iv, 1'b0, 1640, 1'b1, 1);
    drain163();
    req163(1'b0, mul163(bv, cv), bv, cv, 1'b0, 1804, 1'b0, 2);
    drain163();
    req163(1'b1, '0, '0, '0, 1'b1, 2, 1'b0, 3);
    drain163();

    // M=8 directed vectors in the AES field.
    req8(1'b1, 8'h00, 8'h53, 8'hCA, 1'b0, 45, 1, 0, 10, acc); drain8();
    req8(1'b0, 8'h01, 8'h53, 8'hCA, 1'b0, 54, 1, 0, 11, acc); drain8();
    req8(1'b0, 8'h57, 8'h01, 8'h57, 1'b0, 54, 1, 0, 12, acc); drain8();
    req8(1'b0, 8'hC1, 8'h83, 8'h57, 1'b0, 54, 1, 0, 13, acc); drain8();
    req8(1'b1, 8'h00, 8'h02, 8'h8D, 1'b0, 45, 1, 0, 14, acc); drain8();
    req8(1'b0, 8'h00, 8'h53, 8'h00, 1'b0, 54, 1, 0, 15, acc); drain8();
    req8(1'b1, 8'hFF, 8'h01, 8'h01, 1'b0, 45, 1, 0, 16, acc); drain8();

    // Divide-by-zero: err held afterwards, cleared by the next accept.
    req8(1'b0, 8'h57, 8'h00, 8'h00, 1'b1, 2, 1, 0, 17, acc); drain8();
    repeat (3) step();
    chk("m8_err_held", 163'(err8), 163'd1);
    chk("m8_q_zero_held", 163'(q8), 163'd0);
    req8(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 2, 1, 0, 18, acc); drain8();
    req8(1'b1, 8'h00, 8'h53, 8'hCA, 1'b0, 45, 1, 0, 19, acc);
    chk("m8_err_clr", 163'(err8), 163'd0);
    chk("m8_busy_after_accept", 163'(busy8), 163'd1);
    drain8();

    // start held through busy: exactly one result, nothing queued behind it.
    req8(1'b1, 8'h00, 8'h02, 8'h8D, 1'b0, 45, 1, 3, 20, acc); drain8();
    repeat (60) step();

    // Back-to-back: start raised in the done cycle.
    req8(1'b1, 8'h00, 8'h02, 8'h8D, 1'b0, 45, 1, 0, 21, acc);
    n = 0;
    while (!done8 && n < 200) begin step(); n++; end
    if (!done8) begin total++; $display("FAIL m8_b2b_timeout: got done=0 want 1"); end
    s8 = 1'b1; op8 = 1'b0; a8 = 8'h57; b8 = 8'h01;
    e.q = 163'h57; e.err = 1'b0; e.exp_cyc = acc + 45 - 1 + 54 + 1;
    e.chk_inv = 1'b0; e.b = '0; e.tag = 22;
    sb8.push_back(e);
    step();
    step();
    s8 = 1'b0;
    drain8();

    // Reset during SQR, then during MUL: outputs clear, no done follows.
    req8(1'b1, 8'h00, 8'h53, 8'h00, 1'b0, 0, 0, 0, 0, acc);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("m8_rst_sqr_busy", 163'(busy8), 163'd0);
    chk("m8_rst_sqr_q", 163'(q8), 163'd0);
    chk("m8_rst_sqr_done", 163'(done8), 163'd0);
    req8(1'b0, 8'h57, 8'h53, 8'h00, 1'b0, 0, 0, 0, 0, acc);
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("m8_rst_mul_busy", 163'(busy8), 163'd0);
    chk("m8_rst_mul_err", 163'(err8), 163'd0);
    chk("m8_rst_mul_done", 163'(done8), 163'd0);
    repeat (60) step();
    req8(1'b0, 8'hC1, 8'h83, 8'h57, 1'b0, 54, 1, 0, 23, acc); drain8();
    repeat (5) step();

    while (sb8.size() != 0) begin
      void'(sb8.pop_front());
      total++;
      $display("FAIL m8_missing_done: got none want done");
    end
    while (sb163.size() != 0) begin
      void'(sb163.pop_front());
      total++;
      $display("FAIL m163_missing_done: got none want done");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
